// File: rtl/sr_bitcnt_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sr_bitcnt_seq_pkg
// Purpose  : Shared encodings for the Zbb count sequencer: op-select codes
//            (also used by the decoder to drive op) and FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sr_bitcnt_seq_pkg;

  // op-select encodings
  localparam logic [1:0] ZBB_CNT_CLZ  = 2'b00;
  localparam logic [1:0] ZBB_CNT_CTZ  = 2'b01;
  localparam logic [1:0] ZBB_CNT_CPOP = 2'b10;
  localparam logic [1:0] ZBB_CNT_RSVD = 2'b11;

  // sequencer FSM states
  typedef enum logic [1:0] {
    BCS_IDLE = 2'd0,
    BCS_BUSY = 2'd1,
    BCS_DONE = 2'd2
  } bcs_state_t;

endpackage : sr_bitcnt_seq_pkg
`default_nettype wire

// File: rtl/sr_chunk_count.sv
`default_nettype none
// ============================================================================
// Module   : sr_chunk_count
// Purpose  : Combinational counter for one STEP-bit chunk, scanned MSB-first.
// Ports    : chunk  in  STEP      chunk under examination
//            lz     out LZ_W      leading zeros (STEP when chunk is zero)
//            pop    out LZ_W      number of set bits
//            nz     out 1         chunk is nonzero
// Revision : 1.0 - initial release
// ============================================================================
module sr_chunk_count #(
  parameter int STEP = 4,
  parameter int LZ_W = $clog2(STEP) + 1
) (
  input  logic [STEP-1:0] chunk,
  output logic [LZ_W-1:0] lz,
  output logic [LZ_W-1:0] pop,
  output logic            nz
);

  logic seen;

  always_comb begin
    lz   = '0;
    pop  = '0;
    seen = 1'b0;
    for (int i = STEP - 1; i >= 0; i--) begin
      if (chunk[i]) begin
        pop  = pop + LZ_W'(1);
        seen = 1'b1;
      end else if (!seen) begin
        lz = lz + LZ_W'(1);
      end
    end
    nz = |chunk;
  end

endmodule : sr_chunk_count
`default_nettype wire

// File: rtl/sr_bitcnt_seq.sv
`default_nettype none
// ============================================================================
// Module   : sr_bitcnt_seq
// Purpose  : Multi-cycle clz/ctz/cpop sequencer. Scans the operand MSB-first,
//            STEP bits per cycle, stalling the CPU until the count is ready.
//            Latency is fixed at WIDTH/STEP+1 cycles from req to valid.
// Ports    : clk     in  1      CPU clock
//            rst_n   in  1      asynchronous active-low reset
//            req     in  1      current instruction is a count op
//            op      in  2      00 clz, 01 ctz, 10 cpop, 11 reserved
//            srcA    in  WIDTH  operand
//            stall   out 1      freeze pc / regfile write
//            valid   out 1      one-cycle pulse, result valid
//            result  out WIDTH  zero-extended count
// Revision : 1.0 - initial release
// ============================================================================
module sr_bitcnt_seq
  import sr_bitcnt_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4      // must divide WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  output logic             stall,
  output logic             valid,
  output logic [WIDTH-1:0] result
);

  localparam int ACC_W   = $clog2(WIDTH) + 1;
  localparam int LZ_W    = $clog2(STEP) + 1;
  localparam int NCHUNK  = WIDTH / STEP;
  localparam int CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  bcs_state_t       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic             found_q, found_d;
  logic [1:0]       op_q,    op_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0] srcA_rev;
  logic [LZ_W-1:0]  chunk_lz;
  logic [LZ_W-1:0]  chunk_pop;
  logic             chunk_nz;

  // ctz is computed as clz of the bit-reversed operand so every op scans MSB-first
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign srcA_rev[i] = srcA[WIDTH-1-i];
  end

  sr_chunk_count #(
    .STEP (STEP),
    .LZ_W (LZ_W)
  ) u_chunk (
    .chunk (shift_q[WIDTH-1 -: STEP]),
    .lz    (chunk_lz),
    .pop   (chunk_pop),
    .nz    (chunk_nz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BCS_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      found_q  <= 1'b0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      found_q  <= found_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    found_d  = found_q;
    op_d     = op_q;
    result_d = result_q;

    case (state_q)
      BCS_IDLE: begin
        if (req) begin
          shift_d = (op == ZBB_CNT_CTZ) ? srcA_rev : srcA;
          op_d    = op;
          acc_d   = '0;
          found_d = 1'b0;
          cnt_d   = CNT_LAST;
          state_d = BCS_BUSY;
        end
      end

      BCS_BUSY: begin
        shift_d = shift_q << STEP;
        case (op_q)
          ZBB_CNT_CPOP: acc_d = acc_q + ACC_W'(chunk_pop);
          ZBB_CNT_CLZ,
          ZBB_CNT_CTZ: begin
            // leading zeros accumulate only up to and including the first nonzero chunk
            if (!found_q) begin
              acc_d   = acc_q + ACC_W'(chunk_lz);
              found_d = chunk_nz;
            end
          end
          default: ;  // reserved op leaves acc at zero
        endcase
        if (cnt_q == '0) begin
          state_d  = BCS_DONE;
          result_d = WIDTH'(acc_d);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      // req seen here still belongs to the retiring instruction
      BCS_DONE: state_d = BCS_IDLE;

      default:  state_d = BCS_IDLE;
    endcase
  end

  assign stall  = ((state_q == BCS_IDLE) && req) || (state_q == BCS_BUSY);
  assign valid  = (state_q == BCS_DONE);
  assign result = result_q;

endmodule : sr_bitcnt_seq
`default_nettype wire

// File: tb/tb_sr_bitcnt_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_bitcnt_seq
// Purpose  : Directed self-checking bench for sr_bitcnt_seq (WIDTH=32, STEP=4).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_bitcnt_seq;
  import sr_bitcnt_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [1:0]  op;
  logic [31:0] srcA;
  logic        stall;
  logic        valid;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sr_bitcnt_seq #(
    .WIDTH (32),
    .STEP  (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .op     (op),
    .srcA   (srcA),
    .stall  (stall),
    .valid  (valid),
    .result (result)
  );

  // Observe negedges until valid; cyc = negedges before the valid one, -1 on timeout.
  task automatic run_to_valid(output int cyc, output bit stall_ok);
    bit hit;
    hit      = 1'b0;
    cyc      = -1;
    stall_ok = 1'b1;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (valid) begin
        cyc = c;
        hit = 1'b1;
      end else if (!stall) begin
        stall_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req   = 1'b0;
    op    = 2'b00;
    srcA  = 32'h0;
    repeat (2) @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result: got %0d want 0", result); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    req = 1'b1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL reset_stall_req: got %b want 1", stall); end
    req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ops;
    logic [1:0]  v_op [12] = '{2'b00, 2'b01, 2'b10, 2'b01,
                               2'b00, 2'b01, 2'b10,
                               2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
    logic [31:0] v_a  [12] = '{32'h00010000, 32'h00010000, 32'hF0F00001, 32'h80000000,
                               32'h0, 32'h0, 32'h0,
                               32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h0};
    logic [31:0] v_e  [12] = '{32'd15, 32'd16, 32'd9, 32'd31,
                               32'd32, 32'd32, 32'd0,
                               32'd0, 32'd0, 32'd32, 32'd0, 32'd0};
    int cyc;
    bit ok;
    for (int i = 0; i < 12; i++) begin
      op   = v_op[i];
      srcA = v_a[i];
      req  = 1'b1;
      run_to_valid(cyc, ok);
      total++; if (cyc !== 9) begin bad++; $display("FAIL op%0d_latency: got %0d want 9", i, cyc); end
      total++; if (!ok) begin bad++; $display("FAIL op%0d_stall_busy: got 0 want 1", i); end
      total++; if (result !== v_e[i]) begin bad++; $display("FAIL op%0d_result op=%b a=%h: got %0d want %0d", i, v_op[i], v_a[i], result, v_e[i]); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL op%0d_stall_done: got %b want 0", i, stall); end
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL op%0d_valid_pulse: got %b want 0", i, valid); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    int cyc1, cyc2;
    bit ok1, ok2;
    op   = ZBB_CNT_CPOP;
    srcA = 32'h0000000F;
    req  = 1'b1;
    run_to_valid(cyc1, ok1);
    total++; if (cyc1 !== 9) begin bad++; $display("FAIL b2b_first_latency: got %0d want 9", cyc1); end
    total++; if (result !== 32'd4) begin bad++; $display("FAIL b2b_first_result: got %0d want 4", result); end
    @(posedge clk); #1;
    op   = ZBB_CNT_CLZ;
    srcA = 32'h00000001;
    run_to_valid(cyc2, ok2);
    total++; if (cyc1 + 1 + cyc2 !== 19) begin bad++; $display("FAIL b2b_second_cycle: got %0d want 19", cyc1 + 1 + cyc2); end
    total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL b2b_stall_busy: got 0 want 1"); end
    total++; if (result !== 32'd31) begin bad++; $display("FAIL b2b_second_result: got %0d want 31", result); end
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_no_restart: got %b want 0", stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_operand_stability;
    int cyc;
    bit ok;
    op   = ZBB_CNT_CLZ;
    srcA = 32'h00010000;
    req  = 1'b1;
    @(posedge clk); #1;
    op   = ZBB_CNT_CPOP;
    srcA = 32'hFFFFFFFF;
    @(posedge clk); #1;
    srcA = 32'h0;
    run_to_valid(cyc, ok);
    total++; if (cyc !== 7) begin bad++; $display("FAIL stable_latency: got %0d want 7", cyc); end
    total++; if (result !== 32'd15) begin bad++; $display("FAIL stable_result: got %0d want 15", result); end
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    int cyc;
    bit ok;
    op   = ZBB_CNT_CPOP;
    srcA = 32'hFFFFFFFF;
    req  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++; if (dut.state_q !== BCS_BUSY) begin bad++; $display("FAIL arst_pre_busy: got %0d want %0d", dut.state_q, BCS_BUSY); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", valid); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL arst_result: got %0d want 0", result); end
    total++; if (dut.state_q !== BCS_IDLE) begin bad++; $display("FAIL arst_state: got %0d want %0d", dut.state_q, BCS_IDLE); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL arst_stall_req: got %b want 1", stall); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_to_valid(cyc, ok);
    total++; if (cyc !== 9) begin bad++; $display("FAIL arst_restart_latency: got %0d want 9", cyc); end
    total++; if (!ok) begin bad++; $display("FAIL arst_restart_stall: got 0 want 1"); end
    total++; if (result !== 32'd32) begin bad++; $display("FAIL arst_restart_result: got %0d want 32", result); end
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_idle;
    int stall_err = 0;
    int valid_err = 0;
    int res_err   = 0;
    req  = 1'b0;
    op   = ZBB_CNT_CLZ;
    srcA = 32'h00000001;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (stall !== 1'b0) stall_err++;
      if (valid !== 1'b0) valid_err++;
      if (result !== 32'd32) res_err++;
    end
    total++; if (stall_err != 0) begin bad++; $display("FAIL idle_stall: got %0d high cycles want 0", stall_err); end
    total++; if (valid_err != 0) begin bad++; $display("FAIL idle_valid: got %0d high cycles want 0", valid_err); end
    total++; if (res_err != 0) begin bad++; $display("FAIL idle_result_hold: got %0d changed cycles want 0", res_err); end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_operand_stability();
    test_async_reset();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sr_bitcnt_seq
`default_nettype wire
